// File: rtl/mem_stage_access_pkg.sv
// mem_access_pkg: shared encodings for the MEM-stage data-bus access block.
//   - LoadType / StoreType encodings as they arrive from the EX/MEM register
//   - exception codes reported on MEM_ExcCode
//   - FSM state constants for mem_stage_access
//   - byte_en(): access size + low address bits -> little-endian byte enables
package mem_access_pkg;

  // LoadType encodings (5..7 reserved = no load)
  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  // StoreType encodings (3 reserved = no store)
  localparam logic [1:0] ST_SW  = 2'd0;
  localparam logic [1:0] ST_SH  = 2'd1;
  localparam logic [1:0] ST_SB  = 2'd2;
  localparam logic [1:0] ST_RSV = 2'd3;

  // Exception codes
  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd2;
  localparam logic [1:0] EXC_ADES = 2'd3;

  // Access sizes used by byte_en()
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  // FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_WORD: be = 4'b1111;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: be = 4'b0001 << a;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// mem_stage_access_if: SoC data-bus between the MEM stage (master) and memory (slave).
//   req    m->s  request held high for the whole transfer
//   we     m->s  1 = write
//   addr   m->s  word-aligned byte address
//   be     m->s  byte enables, bit0 = lowest byte
//   wdata  m->s  lane-replicated store data
//   ready  s->m  completion; rdata valid in the same cycle
//   rdata  s->m  read data
// Handshake: the master raises req with addr/be/wdata/we stable and keeps all of
// them unchanged until a clock edge where req && ready; that edge completes the
// transfer (read data sampled on it). The master may withdraw req only on timeout.
interface mem_stage_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ready, rdata);
  modport slave  (input req, we, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/mem_stage_access_load_align.sv
// mem_load_align: combinational load-data alignment and extension.
//   rdata_i      32  raw bus word
//   addr_i       2   low address bits of the load
//   load_type_i  3   LoadType encoding
//   data_o       32  aligned, sign/zero-extended result (0 for reserved types)
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half     = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    byte_sel = rdata_i[8*addr_i +: 8];
    case (load_type_i)
      LT_LW:   data_o = rdata_i;
      LT_LH:   data_o = {{16{half[15]}}, half};
      LT_LHU:  data_o = {16'h0000, half};
      LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data_o = {24'h000000, byte_sel};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage data-bus access with stall, alignment and exceptions.
// Ports:
//   clk, reset (async, active-low)
//   MemRead, MemWrite, ALU_result, Memory_Write_data, StoreType, LoadType,
//   ExcCode, mem_flush                    : EX/MEM register inputs
//   MEM_Stall_req, MEM_Load_data, MEM_ExcCode, MEM_Bus_Err : pipeline results
//   dbus                                  : data-bus master (mem_stage_access_if)
//   dbg_state                             : current FSM state (S_IDLE/S_WAIT/S_DONE)
// A transfer is IDLE -> WAIT (req high until ready or timeout) -> DONE -> IDLE.
module mem_stage_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Memory_Write_data,
  input  logic [1:0]  StoreType,
  input  logic [2:0]  LoadType,
  input  logic [1:0]  ExcCode,
  input  logic        mem_flush,
  output logic        MEM_Stall_req,
  output logic [31:0] MEM_Load_data,
  output logic [1:0]  MEM_ExcCode,
  output logic        MEM_Bus_Err,
  mem_stage_access_if.master dbus,
  output logic [1:0]  dbg_state
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, wdata_q, load_data_q;
  logic [3:0]       be_q;
  logic             we_q, flush_q, err_q;
  logic [2:0]       lt_q;
  logic [CNT_W-1:0] cnt_q;

  // Request decode
  logic        is_store, is_load, store_rsv, load_rsv, store_mis, load_mis, access;
  logic        flush_eff, timeout_hit;
  logic [1:0]  load_size;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, aligned;

  always_comb begin
    // Both MemRead and MemWrite set: the store takes precedence.
    is_store  = MemWrite;
    is_load   = MemRead & ~MemWrite;
    store_rsv = (StoreType == ST_RSV);
    load_rsv  = (LoadType > LT_LBU);
    store_mis = is_store & ~store_rsv &
                (((StoreType == ST_SW) & (ALU_result[1:0] != 2'b00)) |
                 ((StoreType == ST_SH) & ALU_result[0]));
    load_mis  = is_load & ~load_rsv &
                (((LoadType == LT_LW) & (ALU_result[1:0] != 2'b00)) |
                 (((LoadType == LT_LH) | (LoadType == LT_LHU)) & ALU_result[0]));
    access    = ((is_store & ~store_rsv) | (is_load & ~load_rsv)) &
                (ExcCode == EXC_NONE) & ~store_mis & ~load_mis & ~mem_flush;

    case (LoadType)
      LT_LW:         load_size = SZ_WORD;
      LT_LH, LT_LHU: load_size = SZ_HALF;
      default:       load_size = SZ_BYTE;
    endcase
    be_d = is_store ? byte_en(StoreType, ALU_result[1:0])
                    : byte_en(load_size, ALU_result[1:0]);

    case (StoreType)
      ST_SH:   wdata_d = {2{Memory_Write_data[15:0]}};
      ST_SB:   wdata_d = {4{Memory_Write_data[7:0]}};
      default: wdata_d = Memory_Write_data;
    endcase
  end

  mem_load_align u_align (
    .rdata_i     (dbus.rdata),
    .addr_i      (addr_q[1:0]),
    .load_type_i (lt_q),
    .data_o      (aligned)
  );

  // A flush arriving in the same cycle as ready still squashes the result.
  assign flush_eff   = flush_q | mem_flush;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (access) state_d = S_WAIT;
      S_WAIT:  if (dbus.ready || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      lt_q        <= '0;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (access) begin
            addr_q  <= ALU_result;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= is_store;
            lt_q    <= LoadType;
            cnt_q   <= '0;
            flush_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_flush) flush_q <= 1'b1;
          if (dbus.ready) begin
            load_data_q <= (!we_q && !flush_eff) ? aligned : 32'h0;
          end else if (timeout_hit) begin
            load_data_q <= 32'h0;
            err_q       <= ~flush_eff;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Bus outputs come only from the latched copies and are quiet outside WAIT.
  logic in_wait;
  assign in_wait    = (state_q == S_WAIT);
  assign dbus.req   = in_wait;
  assign dbus.we    = in_wait & we_q;
  assign dbus.addr  = in_wait ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dbus.be    = in_wait ? be_q : 4'b0000;
  assign dbus.wdata = in_wait ? wdata_q : 32'h0;

  always_comb begin
    MEM_Stall_req = 1'b0;
    MEM_ExcCode   = EXC_NONE;
    case (state_q)
      S_IDLE: begin
        MEM_Stall_req = access;
        if (ExcCode != EXC_NONE) MEM_ExcCode = ExcCode;
        else if (load_mis)       MEM_ExcCode = EXC_ADEL;
        else if (store_mis)      MEM_ExcCode = EXC_ADES;
      end
      S_WAIT:  MEM_Stall_req = 1'b1;
      default: ;
    endcase
  end

  assign MEM_Load_data = load_data_q;
  assign MEM_Bus_Err   = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: directed self-checking bench for mem_stage_access
// (built with TIMEOUT_CYCLES=4 so the abort path is reachable quickly).
module tb_mem_stage_access;
  import mem_access_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        MemRead, MemWrite, mem_flush;
  logic [31:0] ALU_result, Memory_Write_data;
  logic [1:0]  StoreType, ExcCode;
  logic [2:0]  LoadType;
  logic        MEM_Stall_req, MEM_Bus_Err;
  logic [31:0] MEM_Load_data;
  logic [1:0]  MEM_ExcCode, dbg_state;

  mem_stage_access_if dbus ();

  mem_stage_access #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .ALU_result        (ALU_result),
    .Memory_Write_data (Memory_Write_data),
    .StoreType         (StoreType),
    .LoadType          (LoadType),
    .ExcCode           (ExcCode),
    .mem_flush         (mem_flush),
    .MEM_Stall_req     (MEM_Stall_req),
    .MEM_Load_data     (MEM_Load_data),
    .MEM_ExcCode       (MEM_ExcCode),
    .MEM_Bus_Err       (MEM_Bus_Err),
    .dbus              (dbus.master),
    .dbg_state         (dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic mr, input logic mw, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] st, input logic [2:0] lt);
    MemRead = mr; MemWrite = mw; ALU_result = addr;
    Memory_Write_data = wd; StoreType = st; LoadType = lt;
  endtask

  task automatic clr_op();
    MemRead = 1'b0; MemWrite = 1'b0; ALU_result = 32'h0; Memory_Write_data = 32'h0;
    StoreType = ST_SW; LoadType = LT_LW; ExcCode = EXC_NONE; mem_flush = 1'b0;
  endtask

  task automatic bus(input logic rdy, input logic [31:0] rd);
    dbus.ready = rdy;
    dbus.rdata = rd;
  endtask

  // Runs a load that completes on the first WAIT cycle; leaves the bench in IDLE.
  task automatic quick_load(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [31:0] exp);
    set_op(1'b1, 1'b0, addr, 32'h0, ST_SW, lt);
    #1 chk({tag, "_stall_idle"}, 32'(MEM_Stall_req), 32'd1);
    tick();
    bus(1'b1, rd);
    #1 chk({tag, "_req"}, 32'(dbus.req), 32'd1);
    tick();
    bus(1'b0, 32'h0);
    clr_op();
    #1 chk({tag, "_data"}, MEM_Load_data, exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    clr_op();
    bus(1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_req",   32'(dbus.req), 32'd0);
    chk("rst_stall", 32'(MEM_Stall_req), 32'd0);
    chk("rst_data",  MEM_Load_data, 32'h0);
    chk("rst_err",   32'(MEM_Bus_Err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // SW 0x100, ready on first WAIT cycle
    set_op(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, ST_SW, LT_LW);
    #1 chk("sw_stall_idle", 32'(MEM_Stall_req), 32'd1);
    chk("sw_exc", 32'(MEM_ExcCode), 32'd0);
    tick();
    bus(1'b1, 32'h0);
    #1 chk("sw_state_wait", 32'(dbg_state), 32'(S_WAIT));
    chk("sw_stall_wait", 32'(MEM_Stall_req), 32'd1);
    chk("sw_req", 32'(dbus.req), 32'd1);
    chk("sw_we", 32'(dbus.we), 32'd1);
    chk("sw_addr", dbus.addr, 32'h100);
    chk("sw_be", 32'(dbus.be), 32'hF);
    chk("sw_wdata", dbus.wdata, 32'hDEADBEEF);
    tick();
    bus(1'b0, 32'h0);
    clr_op();
    #1 chk("sw_state_done", 32'(dbg_state), 32'(S_DONE));
    chk("sw_stall_done", 32'(MEM_Stall_req), 32'd0);
    chk("sw_req_done", 32'(dbus.req), 32'd0);
    chk("sw_err_done", 32'(MEM_Bus_Err), 32'd0);
    chk("sw_data_done", MEM_Load_data, 32'h0);
    tick();
    chk("sw_back_idle", 32'(dbg_state), 32'(S_IDLE));

    // LB / LBU at 0x203 on 0x80112233
    quick_load("lb",  LT_LB,  32'h203, 32'h80112233, 32'hFFFFFF80);
    chk("lb_hold", MEM_Load_data, 32'hFFFFFF80);
    quick_load("lbu", LT_LBU, 32'h203, 32'h80112233, 32'h00000080);
    quick_load("lh",  LT_LH,  32'h010, 32'h1234F00D, 32'hFFFFF00D);
    quick_load("lw",  LT_LW,  32'h084, 32'hCAFEF00D, 32'hCAFEF00D);

    // SH 0x12 data 0x0000ABCD
    set_op(1'b0, 1'b1, 32'h12, 32'h0000ABCD, ST_SH, LT_LW);
    tick();
    bus(1'b1, 32'h0);
    #1 chk("sh_be", 32'(dbus.be), 32'hC);
    chk("sh_wdata", dbus.wdata, 32'hABCDABCD);
    chk("sh_addr", dbus.addr, 32'h10);
    tick();
    bus(1'b0, 32'h0);
    clr_op();
    #1 chk("sh_data_zero", MEM_Load_data, 32'h0);
    tick();

    // LHU 0x12 on 0xABCD0000, one WAIT cycle without ready
    set_op(1'b1, 1'b0, 32'h12, 32'h0, ST_SW, LT_LHU);
    tick();
    #1 chk("lhu_wait1_req", 32'(dbus.req), 32'd1);
    chk("lhu_wait1_stall", 32'(MEM_Stall_req), 32'd1);
    tick();
    bus(1'b1, 32'hABCD0000);
    #1 chk("lhu_wait2_req", 32'(dbus.req), 32'd1);
    tick();
    bus(1'b0, 32'h0);
    clr_op();
    #1 chk("lhu_data", MEM_Load_data, 32'h0000ABCD);
    chk("lhu_stall_done", 32'(MEM_Stall_req), 32'd0);
    tick();

    // Misaligned LW 0x102 -> AdEL, no bus, no stall
    set_op(1'b1, 1'b0, 32'h102, 32'h0, ST_SW, LT_LW);
    #1 chk("lw_mis_exc", 32'(MEM_ExcCode), 32'(EXC_ADEL));
    chk("lw_mis_stall", 32'(MEM_Stall_req), 32'd0);
    tick();
    chk("lw_mis_req", 32'(dbus.req), 32'd0);
    chk("lw_mis_state", 32'(dbg_state), 32'(S_IDLE));
    // Misaligned SH 0x101 -> AdES
    set_op(1'b0, 1'b1, 32'h101, 32'h1234, ST_SH, LT_LW);
    #1 chk("sh_mis_exc", 32'(MEM_ExcCode), 32'(EXC_ADES));
    chk("sh_mis_stall", 32'(MEM_Stall_req), 32'd0);
    // Upstream exception passes through and blocks the access
    set_op(1'b1, 1'b0, 32'h40, 32'h0, ST_SW, LT_LW);
    ExcCode = 2'd1;
    #1 chk("upstream_exc", 32'(MEM_ExcCode), 32'd1);
    chk("upstream_stall", 32'(MEM_Stall_req), 32'd0);
    // Reserved store type: no access
    ExcCode = EXC_NONE;
    set_op(1'b0, 1'b1, 32'h40, 32'h0, ST_RSV, LT_LW);
    #1 chk("rsv_store_stall", 32'(MEM_Stall_req), 32'd0);
    // Flush in IDLE suppresses the start
    set_op(1'b1, 1'b0, 32'h40, 32'h0, ST_SW, LT_LW);
    mem_flush = 1'b1;
    #1 chk("flush_idle_stall", 32'(MEM_Stall_req), 32'd0);
    tick();
    chk("flush_idle_req", 32'(dbus.req), 32'd0);
    clr_op();

    // MemRead and MemWrite together: SB wins (load check would have misaligned)
    set_op(1'b1, 1'b1, 32'h7, 32'h000000A5, ST_SB, LT_LW);
    #1 chk("both_exc", 32'(MEM_ExcCode), 32'd0);
    chk("both_stall", 32'(MEM_Stall_req), 32'd1);
    tick();
    bus(1'b1, 32'h0);
    #1 chk("both_we", 32'(dbus.we), 32'd1);
    chk("both_be", 32'(dbus.be), 32'h8);
    chk("both_wdata", dbus.wdata, 32'hA5A5A5A5);
    tick();
    bus(1'b0, 32'h0);
    clr_op();
    tick();

    // Seed a nonzero result, then time out a load: 4 WAIT cycles, then abort
    quick_load("seed", LT_LW, 32'h20, 32'h5A5A5A5A, 32'h5A5A5A5A);
    set_op(1'b1, 1'b0, 32'h40, 32'h0, ST_SW, LT_LW);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("to_req_%0d", i), 32'(dbus.req), 32'd1);
      tick();
    end
    clr_op();
    #1 chk("to_req_done", 32'(dbus.req), 32'd0);
    chk("to_err", 32'(MEM_Bus_Err), 32'd1);
    chk("to_data", MEM_Load_data, 32'h0);
    chk("to_state", 32'(dbg_state), 32'(S_DONE));
    tick();
    chk("to_err_pulse", 32'(MEM_Bus_Err), 32'd0);

    // Flush during WAIT of LW: transfer completes, result zeroed, no error
    quick_load("seed2", LT_LW, 32'h24, 32'h11223344, 32'h11223344);
    set_op(1'b1, 1'b0, 32'h80, 32'h0, ST_SW, LT_LW);
    tick();
    mem_flush = 1'b1;
    tick();
    mem_flush = 1'b0;
    #1 chk("fl_req_after_flush", 32'(dbus.req), 32'd1);
    tick();
    bus(1'b1, 32'h12345678);
    #1 chk("fl_req_ready", 32'(dbus.req), 32'd1);
    tick();
    bus(1'b0, 32'h0);
    clr_op();
    #1 chk("fl_state", 32'(dbg_state), 32'(S_DONE));
    chk("fl_data", MEM_Load_data, 32'h0);
    chk("fl_err", 32'(MEM_Bus_Err), 32'd0);
    tick();

    // Reset in WAIT drops req without a clock edge
    set_op(1'b1, 1'b0, 32'h88, 32'h0, ST_SW, LT_LW);
    tick();
    #1 chk("rw_req_before", 32'(dbus.req), 32'd1);
    reset = 1'b0;
    #1 chk("rw_req_after", 32'(dbus.req), 32'd0);
    chk("rw_state", 32'(dbg_state), 32'(S_IDLE));
    clr_op();
    tick();
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
